// File: rtl/atmega_tim_pkg.sv
// Shared constants for the ATmega timer prescaler block: GTCCR layout, tap positions, counter width.
package atmega_tim_pkg;
    localparam int CNT_W = 10;

    localparam int GTCCR_TSM     = 7;
    localparam int GTCCR_PSRASY  = 1;
    localparam int GTCCR_PSRSYNC = 0;

    localparam int TAP_8    = 2;
    localparam int TAP_32   = 4;
    localparam int TAP_64   = 5;
    localparam int TAP_128  = 6;
    localparam int TAP_256  = 7;
    localparam int TAP_1024 = 9;

    typedef struct packed {
        logic tsm;
        logic psrasy;
        logic psrsync;
    } gtccr_t;
endpackage

// File: rtl/atmega_tim_psc_cnt.sv
// Free-running prescaler counter; clear and hold both force it to zero on the next edge.
module atmega_tim_psc_cnt
    import atmega_tim_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             hold_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_o <= '0;
        else if (clr_i || hold_i)
            cnt_o <= '0;
        else
            cnt_o <= cnt_o + CNT_W'(1);
    end

endmodule

// File: rtl/atmega_tim_prescaler_ctrl.sv
// GTCCR owner: sync/async prescaler counters with clear/hold control, and T-pin edge conditioning.
module atmega_tim_prescaler_ctrl
    import atmega_tim_pkg::*;
#(
    parameter int                           BUS_ADDR_DATA_LEN   = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR          = 'h43,
    parameter string                        USE_ASYNC_PRESCALER = "TRUE"
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr_i,
    input  logic                         wr_i,
    input  logic                         rd_i,
    input  logic [7:0]                   bus_i,
    output logic [7:0]                   bus_o,
    output logic                         clk8_o,
    output logic                         clk64_o,
    output logic                         clk256_o,
    output logic                         clk1024_o,
    output logic                         aclk8_o,
    output logic                         aclk32_o,
    output logic                         aclk64_o,
    output logic                         aclk128_o,
    output logic                         aclk256_o,
    output logic                         aclk1024_o,
    input  logic                         t_i,
    output logic                         t_rise_o,
    output logic                         t_fall_o,
    output logic                         sync_hold_o
);

    localparam bit ASYNC_EN = (USE_ASYNC_PRESCALER == "TRUE");

    gtccr_t           gtccr;
    logic [CNT_W-1:0] cs;
    logic [CNT_W-1:0] ca;
    logic             hit;
    logic             wr_hit;
    logic             s1, s2, s3;
    logic             unused_bits;

    assign hit         = (addr_i == GTCCR_ADDR);
    assign wr_hit      = wr_i & hit;
    assign unused_bits = ^bus_i[6:2];

    // With TSM set the PSR bits are sticky; clearing TSM drops both of them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gtccr <= '0;
        end else if (wr_hit) begin
            gtccr.tsm <= bus_i[GTCCR_TSM];
            if (bus_i[GTCCR_TSM]) begin
                gtccr.psrsync <= gtccr.psrsync | bus_i[GTCCR_PSRSYNC];
                gtccr.psrasy  <= ASYNC_EN & (gtccr.psrasy | bus_i[GTCCR_PSRASY]);
            end else begin
                gtccr.psrsync <= 1'b0;
                gtccr.psrasy  <= 1'b0;
            end
        end
    end

    assign sync_hold_o = gtccr.tsm & gtccr.psrsync;

    atmega_tim_psc_cnt u_sync_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (wr_hit & bus_i[GTCCR_PSRSYNC]),
        .hold_i (sync_hold_o),
        .cnt_o  (cs)
    );

    generate
        if (ASYNC_EN) begin : g_async
            atmega_tim_psc_cnt u_async_cnt (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .clr_i  (wr_hit & bus_i[GTCCR_PSRASY]),
                .hold_i (gtccr.tsm & gtccr.psrasy),
                .cnt_o  (ca)
            );
        end else begin : g_no_async
            assign ca = '0;
        end
    endgenerate

    assign clk8_o     = cs[TAP_8];
    assign clk64_o    = cs[TAP_64];
    assign clk256_o   = cs[TAP_256];
    assign clk1024_o  = cs[TAP_1024];
    assign aclk8_o    = ca[TAP_8];
    assign aclk32_o   = ca[TAP_32];
    assign aclk64_o   = ca[TAP_64];
    assign aclk128_o  = ca[TAP_128];
    assign aclk256_o  = ca[TAP_256];
    assign aclk1024_o = ca[TAP_1024];

    assign bus_o = (rd_i && hit) ? {gtccr.tsm, 5'b0, gtccr.psrasy, gtccr.psrsync} : 8'h00;

    // s1 is the metastability stage; edges are detected between s2 and s3.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= t_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign t_rise_o = s2 & ~s3;
    assign t_fall_o = ~s2 & s3;

endmodule

// File: tb/tb_atmega_tim_prescaler_ctrl.sv
// Directed bench for the prescaler controller; a second instance covers the no-async build.
module tb_atmega_tim_prescaler_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] addr = 8'h43;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic       t = 1'b0;

    logic [7:0] bus_o, n_bus_o;
    logic clk8_o, clk64_o, clk256_o, clk1024_o;
    logic aclk8_o, aclk32_o, aclk64_o, aclk128_o, aclk256_o, aclk1024_o;
    logic t_rise_o, t_fall_o, sync_hold_o;
    logic n_clk8_o, n_clk64_o, n_clk256_o, n_clk1024_o;
    logic n_aclk8_o, n_aclk32_o, n_aclk64_o, n_aclk128_o, n_aclk256_o, n_aclk1024_o;
    logic n_t_rise_o, n_t_fall_o, n_sync_hold_o;

    int n_vec = 0;
    int n_err = 0;
    int exp_cs = 0;
    int exp_ca = 0;

    always #5 clk = ~clk;

    atmega_tim_prescaler_ctrl u_dut (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wr_i(wr), .rd_i(rd), .bus_i(bus_in), .bus_o(bus_o),
        .clk8_o(clk8_o), .clk64_o(clk64_o), .clk256_o(clk256_o), .clk1024_o(clk1024_o),
        .aclk8_o(aclk8_o), .aclk32_o(aclk32_o), .aclk64_o(aclk64_o), .aclk128_o(aclk128_o),
        .aclk256_o(aclk256_o), .aclk1024_o(aclk1024_o),
        .t_i(t), .t_rise_o(t_rise_o), .t_fall_o(t_fall_o), .sync_hold_o(sync_hold_o)
    );

    atmega_tim_prescaler_ctrl #(.USE_ASYNC_PRESCALER("FALSE")) u_na (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .wr_i(wr), .rd_i(rd), .bus_i(bus_in), .bus_o(n_bus_o),
        .clk8_o(n_clk8_o), .clk64_o(n_clk64_o), .clk256_o(n_clk256_o), .clk1024_o(n_clk1024_o),
        .aclk8_o(n_aclk8_o), .aclk32_o(n_aclk32_o), .aclk64_o(n_aclk64_o), .aclk128_o(n_aclk128_o),
        .aclk256_o(n_aclk256_o), .aclk1024_o(n_aclk1024_o),
        .t_i(t), .t_rise_o(n_t_rise_o), .t_fall_o(n_t_fall_o), .sync_hold_o(n_sync_hold_o)
    );

    // Advance one edge and sample 1 time unit after it; the bench count follows free running.
    task tick();
        @(posedge clk);
        #1;
        exp_cs = (exp_cs + 1) % 1024;
        exp_ca = (exp_ca + 1) % 1024;
    endtask

    task test_reset();
        logic [13:0] outs;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd = 1'b1;
        #1;
        outs = {clk8_o, clk64_o, clk256_o, clk1024_o, aclk8_o, aclk32_o, aclk64_o, aclk128_o,
                aclk256_o, aclk1024_o, t_rise_o, t_fall_o, sync_hold_o, n_sync_hold_o};
        n_vec++; if (outs !== 14'h0) begin n_err++; $display("FAIL reset_outs: got %h want 0", outs); end
        n_vec++; if (bus_o !== 8'h00) begin n_err++; $display("FAIL reset_gtccr: got %h want 00", bus_o); end
        n_vec++; if (u_dut.cs !== 10'd0) begin n_err++; $display("FAIL reset_cs: got %0d want 0", u_dut.cs); end
        rd = 1'b0;
        rst_n = 1'b1;
        exp_cs = 0;
        exp_ca = 0;
    endtask

    task test_free_run();
        logic [9:0] v;
        for (int k = 1; k <= 1024; k++) begin
            tick();
            v = 10'(exp_cs);
            n_vec++;
            if ({clk1024_o, clk256_o, clk64_o, clk8_o} !== {v[9], v[7], v[5], v[2]}) begin
                n_err++;
                $display("FAIL free_sync_taps edge %0d: got %b want %b", k,
                         {clk1024_o, clk256_o, clk64_o, clk8_o}, {v[9], v[7], v[5], v[2]});
            end
            v = 10'(exp_ca);
            n_vec++;
            if ({aclk1024_o, aclk256_o, aclk128_o, aclk64_o, aclk32_o, aclk8_o} !== {v[9], v[7], v[6], v[5], v[4], v[2]}) begin
                n_err++;
                $display("FAIL free_async_taps edge %0d: got %b want %b", k,
                         {aclk1024_o, aclk256_o, aclk128_o, aclk64_o, aclk32_o, aclk8_o}, {v[9], v[7], v[6], v[5], v[4], v[2]});
            end
        end
        n_vec++; if (u_dut.cs !== 10'd0) begin n_err++; $display("FAIL free_wrap: got %0d want 0", u_dut.cs); end
    endtask

    task test_sync_clear();
        repeat (37) tick();
        n_vec++; if (u_dut.cs !== 10'd37) begin n_err++; $display("FAIL sclr_pre: got %0d want 37", u_dut.cs); end
        bus_in = 8'h01; wr = 1'b1;
        tick();
        exp_cs = 0;
        n_vec++; if (u_dut.cs !== 10'd0) begin n_err++; $display("FAIL sclr_cs: got %0d want 0", u_dut.cs); end
        n_vec++; if (u_dut.ca !== 10'd38) begin n_err++; $display("FAIL sclr_ca: got %0d want 38", u_dut.ca); end
        n_vec++; if ({aclk64_o, aclk8_o} !== 2'b11) begin n_err++; $display("FAIL sclr_ataps: got %b want 11", {aclk64_o, aclk8_o}); end
        wr = 1'b0; rd = 1'b1;
        #1;
        n_vec++; if (bus_o !== 8'h00) begin n_err++; $display("FAIL sclr_read: got %h want 00", bus_o); end
        tick();
        n_vec++; if (u_dut.cs !== 10'd1) begin n_err++; $display("FAIL sclr_resume: got %0d want 1", u_dut.cs); end
        repeat (2) tick();
        n_vec++; if (clk8_o !== 1'b0) begin n_err++; $display("FAIL sclr_clk8_early: got %b want 0", clk8_o); end
        tick();
        n_vec++; if (clk8_o !== 1'b1) begin n_err++; $display("FAIL sclr_clk8_rise: got %b want 1", clk8_o); end
        rd = 1'b0;
    endtask

    task test_hold();
        bus_in = 8'h81; wr = 1'b1;
        tick();
        exp_cs = 0;
        wr = 1'b0; rd = 1'b1;
        #1;
        n_vec++; if (sync_hold_o !== 1'b1) begin n_err++; $display("FAIL hold_flag: got %b want 1", sync_hold_o); end
        n_vec++; if (bus_o !== 8'h81) begin n_err++; $display("FAIL hold_read: got %h want 81", bus_o); end
        n_vec++; if (n_bus_o !== 8'h81) begin n_err++; $display("FAIL hold_read_na: got %h want 81", n_bus_o); end
        for (int i = 0; i < 100; i++) begin
            tick();
            exp_cs = 0;
            n_vec++; if (u_dut.cs !== 10'd0) begin n_err++; $display("FAIL hold_cs cyc %0d: got %0d want 0", i, u_dut.cs); end
        end
        bus_in = 8'h00; wr = 1'b1;
        #1;
        n_vec++; if (bus_o !== 8'h81) begin n_err++; $display("FAIL hold_rdwr: got %h want 81", bus_o); end
        tick();
        exp_cs = 0;
        n_vec++; if (u_dut.cs !== 10'd0) begin n_err++; $display("FAIL release_edge: got %0d want 0", u_dut.cs); end
        wr = 1'b0;
        #1;
        n_vec++; if (bus_o !== 8'h00) begin n_err++; $display("FAIL release_read: got %h want 00", bus_o); end
        n_vec++; if (sync_hold_o !== 1'b0) begin n_err++; $display("FAIL release_flag: got %b want 0", sync_hold_o); end
        tick();
        n_vec++; if (u_dut.cs !== 10'd1) begin n_err++; $display("FAIL release_cs: got %0d want 1", u_dut.cs); end
        rd = 1'b0;
    endtask

    task test_both_hold();
        bus_in = 8'h83; wr = 1'b1;
        tick();
        bus_in = 8'h80;
        tick();
        wr = 1'b0; rd = 1'b1;
        #1;
        n_vec++; if (bus_o !== 8'h83) begin n_err++; $display("FAIL both_read: got %h want 83", bus_o); end
        n_vec++; if (n_bus_o !== 8'h81) begin n_err++; $display("FAIL both_read_na: got %h want 81", n_bus_o); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_vec++; if ({u_dut.cs, u_dut.ca} !== 20'd0) begin n_err++; $display("FAIL both_held cyc %0d: got %0d/%0d want 0/0", i, u_dut.cs, u_dut.ca); end
        end
        bus_in = 8'h00; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
        exp_cs = 1; exp_ca = 1;
        n_vec++; if ({u_dut.cs, u_dut.ca} !== {10'd1, 10'd1}) begin n_err++; $display("FAIL both_release: got %0d/%0d want 1/1", u_dut.cs, u_dut.ca); end
        rd = 1'b0;
    endtask

    task test_async_clear();
        repeat (499) tick();
        n_vec++; if (aclk256_o !== 1'b1) begin n_err++; $display("FAIL aclr_pre: got %b want 1", aclk256_o); end
        bus_in = 8'h02; wr = 1'b1;
        tick();
        exp_ca = 0;
        n_vec++; if (u_dut.ca !== 10'd0) begin n_err++; $display("FAIL aclr_ca: got %0d want 0", u_dut.ca); end
        n_vec++; if (u_dut.cs !== 10'd501) begin n_err++; $display("FAIL aclr_cs: got %0d want 501", u_dut.cs); end
        n_vec++; if ({aclk256_o, clk256_o} !== 2'b01) begin n_err++; $display("FAIL aclr_taps: got %b want 01", {aclk256_o, clk256_o}); end
        n_vec++; if ({n_aclk256_o, n_aclk8_o} !== 2'b00) begin n_err++; $display("FAIL aclr_na_taps: got %b want 00", {n_aclk256_o, n_aclk8_o}); end
        wr = 1'b0;
        tick();
        n_vec++; if ({u_dut.ca, u_dut.cs} !== {10'd1, 10'd502}) begin n_err++; $display("FAIL aclr_resume: got %0d/%0d want 1/502", u_dut.ca, u_dut.cs); end
    endtask

    task test_bad_addr();
        addr = 8'h44; bus_in = 8'h81; wr = 1'b1; rd = 1'b1;
        tick();
        wr = 1'b0;
        #1;
        n_vec++; if (sync_hold_o !== 1'b0) begin n_err++; $display("FAIL badaddr_hold: got %b want 0", sync_hold_o); end
        n_vec++; if (u_dut.cs !== 10'(exp_cs)) begin n_err++; $display("FAIL badaddr_cs: got %0d want %0d", u_dut.cs, exp_cs); end
        n_vec++; if (bus_o !== 8'h00) begin n_err++; $display("FAIL badaddr_read: got %h want 00", bus_o); end
        addr = 8'h43; rd = 1'b0;
    endtask

    task test_t_pin();
        #6; t = 1'b1;
        tick();
        n_vec++; if (t_rise_o !== 1'b0) begin n_err++; $display("FAIL trise_early: got %b want 0", t_rise_o); end
        tick();
        n_vec++; if ({t_rise_o, t_fall_o} !== 2'b10) begin n_err++; $display("FAIL trise_pulse: got %b want 10", {t_rise_o, t_fall_o}); end
        tick();
        n_vec++; if (t_rise_o !== 1'b0) begin n_err++; $display("FAIL trise_end: got %b want 0", t_rise_o); end
        #6; t = 1'b0;
        tick();
        n_vec++; if (t_fall_o !== 1'b0) begin n_err++; $display("FAIL tfall_early: got %b want 0", t_fall_o); end
        tick();
        n_vec++; if ({t_rise_o, t_fall_o} !== 2'b01) begin n_err++; $display("FAIL tfall_pulse: got %b want 01", {t_rise_o, t_fall_o}); end
        tick();
        n_vec++; if (t_fall_o !== 1'b0) begin n_err++; $display("FAIL tfall_end: got %b want 0", t_fall_o); end
    endtask

    task test_reset_mid_pulse();
        #6; t = 1'b1;
        tick();
        tick();
        n_vec++; if (t_rise_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got %b want 1", t_rise_o); end
        #2; rst_n = 1'b0;
        #1;
        n_vec++; if ({t_rise_o, t_fall_o, sync_hold_o} !== 3'b000) begin n_err++; $display("FAIL midrst_t: got %b want 000", {t_rise_o, t_fall_o, sync_hold_o}); end
        n_vec++; if (u_dut.cs !== 10'd0) begin n_err++; $display("FAIL midrst_cs: got %0d want 0", u_dut.cs); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cs = 0; exp_ca = 0;
        tick();
        n_vec++; if (t_rise_o !== 1'b0) begin n_err++; $display("FAIL relhigh_e1: got %b want 0", t_rise_o); end
        tick();
        n_vec++; if (t_rise_o !== 1'b1) begin n_err++; $display("FAIL relhigh_e2: got %b want 1", t_rise_o); end
        tick();
        n_vec++; if (t_rise_o !== 1'b0) begin n_err++; $display("FAIL relhigh_e3: got %b want 0", t_rise_o); end
        n_vec++; if (u_dut.cs !== 10'd3) begin n_err++; $display("FAIL relhigh_cs: got %0d want 3", u_dut.cs); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_sync_clear();
        test_hold();
        test_both_hold();
        test_async_clear();
        test_bad_addr();
        test_t_pin();
        test_reset_mid_pulse();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
